mcp23017_target: RTL
====================

MCP23017_TARGET -- requirements
Module: mcp23017_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b010_0000, meaning the 7-bit I2C target address this block answers to.
REQ-002 SHALL have port clk_i  input  1  system clock, at least 10x SCL frequency.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low; clock is clk_i.
REQ-004 SHALL have port srst_i  input  1  synchronous reset; same effect as rst_ni.
REQ-005 SHALL have ports scl_i, sda_i  input  1 each  raw bus lines.
REQ-006 SHALL have ports sda_o, sda_t  output  1 each  open-drain SDA: sda_o constant 0; sda_t=1 releases the line, sda_t=0 pulls it low.
REQ-007 SHALL have ports gpio_a_i, gpio_b_i  input  8 each  pin values returned on GPIOA/GPIOB reads.
REQ-008 SHALL have ports iodir_a_o, iodir_b_o, gppu_a_o, gppu_b_o, olat_a_o, olat_b_o  output  8 each  register contents.
REQ-009 SHALL have port wr_stb_o  output  1  one-cycle pulse per accepted register write.
REQ-010 SHALL have ports wr_addr_o, wr_data_o  output  8 each  pointer and data of the last accepted write.
REQ-011 SHALL have port busy_o  output  1  high from the address match until STOP or NACK.

Function
REQ-012 SHALL pass scl_i and sda_i through two-flop synchronisers; all edge detection SHALL use synchronised values.
REQ-013 SHALL detect START/Sr as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high, in any state.
REQ-014 SHALL implement states IDLE, DADDR, DADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
REQ-015 START SHALL enter DADDR from any state; STOP SHALL enter IDLE from any state and release SDA.
REQ-016 SHALL sample bits MSB-first on SCL rising edges and change SDA only on SCL falling edges.
REQ-017 After 8 DADDR bits: an address mismatch SHALL go to WAIT with no ACK; a match SHALL drive ACK low for the 9th clock.
REQ-018 A match with R/W=0 SHALL proceed to PTR; a match with R/W=1 SHALL proceed to RDATA, loading the shifter from register[ptr].
REQ-019 The PTR byte SHALL be ACKed and loaded into the 8-bit pointer, then WDATA SHALL follow.
REQ-020 Each WDATA byte SHALL be ACKed and written to register[ptr], pulse wr_stb_o once, then increment the pointer.
REQ-021 The register map SHALL be:
- 0x00 IODIRA, reset 0xFF
- 0x01 IODIRB, reset 0xFF
- 0x0C GPPUA, reset 0x00
- 0x0D GPPUB, reset 0x00
- 0x12 GPIOA: reads gpio_a_i; a write updates OLATA
- 0x13 GPIOB: reads gpio_b_i; a write updates OLATB
- 0x14 OLATA, reset 0x00
- 0x15 OLATB, reset 0x00
REQ-022 Unmapped addresses SHALL read 0x00; writes to them SHALL be ACKed and ignored, with no wr_stb_o.
REQ-023 The pointer SHALL increment after every data byte and wrap from 0x15 to 0x00; values above 0x15 SHALL wrap modulo 256.
REQ-024 The pointer SHALL persist across STOP and Sr, so "write PTR, Sr, read" returns register[PTR].
REQ-025 In RDATA, the block SHALL release SDA for the ACK clock and sample the master ACK on the 9th rising edge.
REQ-026 A master ACK SHALL increment the pointer and load the next byte; a NACK SHALL go to WAIT with SDA released.
REQ-027 GPIOA/GPIOB read values SHALL be sampled at the SCL falling edge at which the byte's MSB is driven.
REQ-028 Bit counting SHALL be 3-bit; the 9th clock SHALL be tracked by the ACK states.
REQ-029 A START or STOP in the middle of a byte SHALL abort the byte with no register write.

Reset
REQ-030 On rst_ni low or srst_i high, the block SHALL:
- enter IDLE
- set sda_t=1, pointer=0x00, wr_stb_o=0, busy_o=0, wr_addr_o=0, wr_data_o=0
- restore all registers to their REQ-021 reset values
REQ-031 Reset in the middle of a transfer SHALL release SDA within one clk_i cycle; the next valid START SHALL then be honoured.

Verification
REQ-032 Write S,0x40,0x14,0xA5,P -> three ACKs, olat_a_o=0xA5, one wr_stb_o with wr_addr_o=0x14 and wr_data_o=0xA5.
REQ-033 Set gpio_b_i=0x3C, then S,0x40,0x13,Sr,0x41,read,NACK,P -> read byte 0x3C, SDA released after NACK, busy_o=0.
REQ-034 Write S,0x40,0x14,0x11,0x22,0x33,P -> OLATA=0x11, OLATB=0x22, IODIRA=0x33 (wrap), three wr_stb_o pulses.
REQ-035 Write S,0x42,... with DEV_ADDR=0x20 -> no ACK, SDA never driven, registers unchanged until the next START.
REQ-036 Assert srst_i during the ACK clock of the PTR byte -> SDA released, IODIRA/IODIRB=0xFF, pointer=0x00, and a following transfer completes normally.

Source files
------------

// File: rtl/mcp23017_target.sv
// I2C target emulating the MCP23017 register subset (IODIR, GPPU, GPIO, OLAT for ports A/B).
// The bus lines are synchronised to clk_i, and all protocol actions are keyed off synchronised SCL/SDA edges.
module mcp23017_target #(
   parameter logic [6:0] DEV_ADDR = 7'b010_0000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       srst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_t,
   input  logic [7:0] gpio_a_i,
   input  logic [7:0] gpio_b_i,
   output logic [7:0] iodir_a_o,
   output logic [7:0] iodir_b_o,
   output logic [7:0] gppu_a_o,
   output logic [7:0] gppu_b_o,
   output logic [7:0] olat_a_o,
   output logic [7:0] olat_b_o,
   output logic       wr_stb_o,
   output logic [7:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       busy_o
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 3;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_DADDR     = 4'd1;
   localparam logic [3:0] S_DADDR_ACK = 4'd2;
   localparam logic [3:0] S_PTR       = 4'd3;
   localparam logic [3:0] S_PTR_ACK   = 4'd4;
   localparam logic [3:0] S_WDATA     = 4'd5;
   localparam logic [3:0] S_WDATA_ACK = 4'd6;
   localparam logic [3:0] S_RDATA     = 4'd7;
   localparam logic [3:0] S_RDATA_ACK = 4'd8;
   localparam logic [3:0] S_WAIT      = 4'd9;

   localparam logic [DW-1:0] A_IODIRA = 8'h00;
   localparam logic [DW-1:0] A_IODIRB = 8'h01;
   localparam logic [DW-1:0] A_GPPUA  = 8'h0C;
   localparam logic [DW-1:0] A_GPPUB  = 8'h0D;
   localparam logic [DW-1:0] A_GPIOA  = 8'h12;
   localparam logic [DW-1:0] A_GPIOB  = 8'h13;
   localparam logic [DW-1:0] A_OLATA  = 8'h14;
   localparam logic [DW-1:0] A_OLATB  = 8'h15;

   // Two-flop synchronisers plus one delayed copy for edge detection
   logic [1:0] scl_sync, sda_sync;
   logic       scl_d, sda_d;
   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
   assign sda_o     = 1'b0;

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [DW-1:0] ptr_q, ptr_d;
   logic          ack_ph_q, ack_ph_d;
   logic          rw_q, rw_d;
   logic          sda_t_q, sda_t_d;
   logic          busy_q, busy_d;
   logic          wr_stb_q, wr_stb_d;
   logic [DW-1:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
   logic [DW-1:0] iodir_a_q, iodir_a_d, iodir_b_q, iodir_b_d;
   logic [DW-1:0] gppu_a_q, gppu_a_d, gppu_b_q, gppu_b_d;
   logic [DW-1:0] olat_a_q, olat_a_d, olat_b_q, olat_b_d;
   logic [DW-1:0] rx_byte, ptr_inc, rd_data;

   assign rx_byte = {shift_q[6:0], sda_s};
   assign ptr_inc = (ptr_q == A_OLATB) ? 8'h00 : ptr_q + 8'h01;

   // Read mux; GPIO pins are sampled when the byte is loaded into the shifter
   always_comb begin
      rd_data = 8'h00;
      case (ptr_q)
         A_IODIRA: rd_data = iodir_a_q;
         A_IODIRB: rd_data = iodir_b_q;
         A_GPPUA:  rd_data = gppu_a_q;
         A_GPPUB:  rd_data = gppu_b_q;
         A_GPIOA:  rd_data = gpio_a_i;
         A_GPIOB:  rd_data = gpio_b_i;
         A_OLATA:  rd_data = olat_a_q;
         A_OLATB:  rd_data = olat_b_q;
         default:  rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         ack_ph_q  <= 1'b0;
         rw_q      <= 1'b0;
         sda_t_q   <= 1'b1;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         iodir_a_q <= 8'hFF;
         iodir_b_q <= 8'hFF;
         gppu_a_q  <= 8'h00;
         gppu_b_q  <= 8'h00;
         olat_a_q  <= 8'h00;
         olat_b_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         ack_ph_q  <= ack_ph_d;
         rw_q      <= rw_d;
         sda_t_q   <= sda_t_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         iodir_a_q <= iodir_a_d;
         iodir_b_q <= iodir_b_d;
         gppu_a_q  <= gppu_a_d;
         gppu_b_q  <= gppu_b_d;
         olat_a_q  <= olat_a_d;
         olat_b_q  <= olat_b_d;
      end
   end

   // Protocol FSM; ack_ph marks the second half of a 9th-clock phase
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      ack_ph_d  = ack_ph_q;
      rw_d      = rw_q;
      sda_t_d   = sda_t_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      iodir_a_d = iodir_a_q;
      iodir_b_d = iodir_b_q;
      gppu_a_d  = gppu_a_q;
      gppu_b_d  = gppu_b_q;
      olat_a_d  = olat_a_q;
      olat_b_d  = olat_b_q;

      if (start_det) begin
         state_d   = S_DADDR;
         bit_cnt_d = '0;
         ack_ph_d  = 1'b0;
         sda_t_d   = 1'b1;
      end else if (stop_det) begin
         state_d  = S_IDLE;
         ack_ph_d = 1'b0;
         sda_t_d  = 1'b1;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            S_DADDR: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                     state_d  = S_DADDR_ACK;
                     rw_d     = rx_byte[0];
                     busy_d   = 1'b1;
                     ack_ph_d = 1'b0;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            end
            S_PTR: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  ptr_d    = rx_byte;
                  state_d  = S_PTR_ACK;
                  ack_ph_d = 1'b0;
               end
            end
            S_WDATA: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_byte;
                  case (ptr_q)
                     A_IODIRA:         iodir_a_d = rx_byte;
                     A_IODIRB:         iodir_b_d = rx_byte;
                     A_GPPUA:          gppu_a_d  = rx_byte;
                     A_GPPUB:          gppu_b_d  = rx_byte;
                     A_GPIOA, A_OLATA: olat_a_d  = rx_byte;
                     A_GPIOB, A_OLATB: olat_b_d  = rx_byte;
                     default: begin
                        wr_stb_d  = 1'b0;
                        wr_addr_d = wr_addr_q;
                        wr_data_d = wr_data_q;
                     end
                  endcase
                  ptr_d    = ptr_inc;
                  state_d  = S_WDATA_ACK;
                  ack_ph_d = 1'b0;
               end
            end
            S_DADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
               if (!ack_ph_q) begin
                  sda_t_d  = 1'b0;
                  ack_ph_d = 1'b1;
               end else begin
                  ack_ph_d  = 1'b0;
                  bit_cnt_d = '0;
                  sda_t_d   = 1'b1;
                  if (state_q == S_DADDR_ACK && rw_q) begin
                     shift_d = rd_data;
                     sda_t_d = rd_data[7];
                     state_d = S_RDATA;
                  end else if (state_q == S_DADDR_ACK) begin
                     state_d = S_PTR;
                  end else begin
                     state_d = S_WDATA;
                  end
               end
            end
            S_RDATA: if (scl_fall) begin
               if (bit_cnt_q == 3'd7) begin
                  sda_t_d  = 1'b1;
                  state_d  = S_RDATA_ACK;
                  ack_ph_d = 1'b0;
               end else begin
                  shift_d   = {shift_q[6:0], shift_q[7]};
                  sda_t_d   = shift_q[6];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            S_RDATA_ACK: begin
               if (scl_rise && !ack_ph_q) begin
                  if (!sda_s) begin
                     ptr_d    = ptr_inc;
                     ack_ph_d = 1'b1;
                  end else begin
                     state_d = S_WAIT;
                     busy_d  = 1'b0;
                     sda_t_d = 1'b1;
                  end
               end else if (scl_fall && ack_ph_q) begin
                  shift_d   = rd_data;
                  sda_t_d   = rd_data[7];
                  bit_cnt_d = '0;
                  ack_ph_d  = 1'b0;
                  state_d   = S_RDATA;
               end
            end
            default: ;
         endcase
      end

      if (srst_i) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         ptr_d     = '0;
         ack_ph_d  = 1'b0;
         rw_d      = 1'b0;
         sda_t_d   = 1'b1;
         busy_d    = 1'b0;
         wr_stb_d  = 1'b0;
         wr_addr_d = '0;
         wr_data_d = '0;
         iodir_a_d = 8'hFF;
         iodir_b_d = 8'hFF;
         gppu_a_d  = 8'h00;
         gppu_b_d  = 8'h00;
         olat_a_d  = 8'h00;
         olat_b_d  = 8'h00;
      end
   end

   assign sda_t     = sda_t_q;
   assign busy_o    = busy_q;
   assign wr_stb_o  = wr_stb_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign iodir_a_o = iodir_a_q;
   assign iodir_b_o = iodir_b_q;
   assign gppu_a_o  = gppu_a_q;
   assign gppu_b_o  = gppu_b_q;
   assign olat_a_o  = olat_a_q;
   assign olat_b_o  = olat_b_q;

endmodule
